// File: rtl/voice_mixer_pkg.sv
// Shared definitions for the voice mixer: FSM encoding and unity-gain helper.
package voice_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mix_state_t;

    localparam int DEFAULT_GAIN_SHIFT = 3;

    // Unity gain is a one in the integer position of the fixed-point gain.
    function automatic int unity_gain(input int shift);
        return 1 << shift;
    endfunction

    localparam int UNITY_GAIN = unity_gain(DEFAULT_GAIN_SHIFT);

endpackage

// File: rtl/mixer_gain_bank.sv
// Per-channel gain and mute registers with saturating up/down control.
module mixer_gain_bank
    import voice_mixer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int GAIN_W     = 4,
    parameter int GAIN_SHIFT = 3,
    parameter int SEL_W      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         gain_sel,
    input  logic                     gain_up,
    input  logic                     gain_down,
    input  logic                     mute_toggle,
    output logic [NUM_CH*GAIN_W-1:0] gains,
    output logic [NUM_CH-1:0]        mutes,
    output logic [GAIN_W-1:0]        sel_gain
);

    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_SHIFT));

    // Apply control pulses to the selected channel; out-of-range selects match nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                gains[i*GAIN_W +: GAIN_W] <= UNITY;
            end
            mutes <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(gain_sel) == i) begin
                    if (gain_up && !gain_down && gains[i*GAIN_W +: GAIN_W] != '1) begin
                        gains[i*GAIN_W +: GAIN_W] <= gains[i*GAIN_W +: GAIN_W] + 1'b1;
                    end else if (gain_down && !gain_up && gains[i*GAIN_W +: GAIN_W] != '0) begin
                        gains[i*GAIN_W +: GAIN_W] <= gains[i*GAIN_W +: GAIN_W] - 1'b1;
                    end
                    if (mute_toggle) begin
                        mutes[i] <= ~mutes[i];
                    end
                end
            end
        end
    end

    // Live gain of the selected channel for display; reads 0 when nothing matches.
    always_comb begin
        sel_gain = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(gain_sel) == i) begin
                sel_gain = gains[i*GAIN_W +: GAIN_W];
            end
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Multi-channel voice mixer: serial multiply-accumulate over a captured sample set
// with per-channel gain/mute, saturated to the sample range.
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 4,
    parameter int GAIN_SHIFT = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0]             samples_in,
    input  logic [(NUM_CH>1?$clog2(NUM_CH):1)-1:0] gain_sel,
    input  logic                                   gain_up,
    input  logic                                   gain_down,
    input  logic                                   mute_toggle,
    output logic [SAMPLE_W-1:0]                    out,
    output logic                                   out_ready,
    output logic                                   busy,
    output logic                                   dropped,
    output logic [GAIN_W-1:0]                      sel_gain
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W  = SAMPLE_W + GAIN_W + IDX_W;
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    mix_state_t                 state;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic [NUM_CH*SAMPLE_W-1:0] samples_q;
    logic [NUM_CH*GAIN_W-1:0]   gains_q;
    logic [NUM_CH-1:0]          mutes_q;
    logic                       pend;

    logic [NUM_CH*GAIN_W-1:0]   gains_live;
    logic [NUM_CH-1:0]          mutes_live;

    logic signed [SAMPLE_W-1:0] sample_cur;
    logic [GAIN_W-1:0]          gain_cur;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    term;
    logic [SAMPLE_W-1:0]        sat_val;

    mixer_gain_bank #(
        .NUM_CH     (NUM_CH),
        .GAIN_W     (GAIN_W),
        .GAIN_SHIFT (GAIN_SHIFT),
        .SEL_W      (IDX_W)
    ) u_gain_bank (
        .clk         (clk),
        .reset       (reset),
        .gain_sel    (gain_sel),
        .gain_up     (gain_up),
        .gain_down   (gain_down),
        .mute_toggle (mute_toggle),
        .gains       (gains_live),
        .mutes       (mutes_live),
        .sel_gain    (sel_gain)
    );

    assign busy = (state != IDLE);

    // Select the current channel's operands so one multiplier serves every channel.
    always_comb begin
        sample_cur = '0;
        gain_cur   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(idx) == i) begin
                sample_cur = samples_q[i*SAMPLE_W +: SAMPLE_W];
                gain_cur   = gains_q[i*GAIN_W +: GAIN_W];
            end
        end
        prod = PROD_W'(sample_cur) * PROD_W'($signed({1'b0, gain_cur}));
        if (mutes_q[idx]) begin
            term = '0;
        end else begin
            term = ACC_W'(prod >>> GAIN_SHIFT);
        end
    end

    // Clamp the wide accumulator into the signed sample range.
    always_comb begin
        if (acc > SAT_MAX) begin
            sat_val = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            sat_val = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            sat_val = acc[SAMPLE_W-1:0];
        end
    end

    // Mix sequencer. SAT only arms pend; out and out_ready move together on the
    // following edge, when the FSM is already back in IDLE and can accept a new set.
    // acc is still valid at that edge because nothing clears it before then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            samples_q <= '0;
            gains_q   <= '0;
            mutes_q   <= '0;
            pend      <= 1'b0;
            out       <= '0;
            out_ready <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            out_ready <= pend;
            pend      <= 1'b0;
            if (pend) begin
                out <= sat_val;
            end
            if (in_ready && state != IDLE) begin
                dropped <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_ready) begin
                        samples_q <= samples_in;
                        gains_q   <= gains_live;
                        mutes_q   <= mutes_live;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= SAT;
                    end
                end
                SAT: begin
                    pend  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer with a behavioural mixing model.
module tb_voice_mixer;

    logic        clk;
    logic        reset;
    logic        in_ready;
    logic [63:0] samples_in;
    logic [1:0]  gain_sel;
    logic        gain_up;
    logic        gain_down;
    logic        mute_toggle;
    logic signed [15:0] out;
    logic        out_ready;
    logic        busy;
    logic        dropped;
    logic [3:0]  sel_gain;

    int tests = 0;
    int fails = 0;

    int smp[4];
    int m_gain[4];
    bit m_mute[4];

    voice_mixer #(
        .NUM_CH(4), .SAMPLE_W(16), .GAIN_W(4), .GAIN_SHIFT(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_ready    (in_ready),
        .samples_in  (samples_in),
        .gain_sel    (gain_sel),
        .gain_up     (gain_up),
        .gain_down   (gain_down),
        .mute_toggle (mute_toggle),
        .out         (out),
        .out_ready   (out_ready),
        .busy        (busy),
        .dropped     (dropped),
        .sel_gain    (sel_gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected mix: each unmuted channel contributes floor(sample*gain/8), then clamp.
    function automatic int model_mix();
        int acc;
        int p;
        acc = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (!m_mute[ch]) begin
                p = smp[ch] * m_gain[ch];
                if (p >= 0) acc += p / 8;
                else        acc -= (-p + 7) / 8;
            end
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            m_gain[ch] = 8;
            m_mute[ch] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_in();
        for (int ch = 0; ch < 4; ch++) samples_in[ch*16 +: 16] = 16'(smp[ch]);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic gain_pulse(input int sel, input bit up, input bit dn, input bit mt);
        gain_sel    = 2'(sel);
        gain_up     = up;
        gain_down   = dn;
        mute_toggle = mt;
        tick();
        gain_up     = 1'b0;
        gain_down   = 1'b0;
        mute_toggle = 1'b0;
        if (up && !dn && m_gain[sel] < 15) m_gain[sel]++;
        else if (dn && !up && m_gain[sel] > 0) m_gain[sel]--;
        if (mt) m_mute[sel] = !m_mute[sel];
    endtask

    // Called n0 cycles after the in_ready edge; returns in the out_ready cycle.
    task automatic expect_mix(input string tag, input int exp_val, input int n0);
        int n;
        int busy_n;
        n = n0;
        busy_n = busy ? 1 : 0;
        while (out_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (busy) busy_n++;
        end
        check({tag, "_latency"}, n, 6);
        check({tag, "_out"}, out, exp_val);
        if (n0 == 0) check({tag, "_busy_cycles"}, busy_n, 5);
    endtask

    initial begin
        int exp_a;
        int exp_b;
        int cnt;
        int n0;

        reset = 1'b1;
        in_ready = 1'b0;
        samples_in = '0;
        gain_sel = '0;
        gain_up = 1'b0;
        gain_down = 1'b0;
        mute_toggle = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_out", out, 0);
        check("rst_out_ready", out_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_dropped", dropped, 0);
        reset = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) begin
            gain_sel = 2'(s);
            #1;
            check($sformatf("rst_sel_gain%0d", s), sel_gain, 8);
        end
        gain_sel = 2'd0;

        // Unity mix and one-cycle out_ready
        smp = '{1000, 2000, -500, 100};
        pulse_in();
        expect_mix("unity", 2600, 0);
        tick();
        check("unity_pulse_width", out_ready, 0);
        check("unity_out_held", out, 2600);

        // Saturation both ways
        smp = '{30000, 30000, 30000, 30000};
        pulse_in();
        expect_mix("sat_pos", 32767, 0);
        smp = '{-30000, -30000, -30000, -30000};
        pulse_in();
        expect_mix("sat_neg", -32768, 0);

        // Gain down / up saturation and mute on channel 1
        for (int k = 0; k < 4; k++) gain_pulse(1, 0, 1, 0);
        check("gain_down4", sel_gain, 4);
        smp = '{0, 1000, 0, 0};
        pulse_in();
        expect_mix("half_gain", 500, 0);
        for (int k = 0; k < 10; k++) gain_pulse(1, 0, 1, 0);
        check("gain_floor", sel_gain, 0);
        gain_pulse(1, 1, 1, 0);
        check("gain_up_down_same", sel_gain, 0);
        for (int k = 0; k < 20; k++) gain_pulse(1, 1, 0, 0);
        check("gain_ceiling", sel_gain, 15);
        gain_pulse(1, 0, 0, 1);
        pulse_in();
        expect_mix("mute", 0, 0);
        gain_pulse(1, 0, 0, 1);
        for (int k = 0; k < 7; k++) gain_pulse(1, 0, 1, 0);
        check("gain_restore", sel_gain, 8);

        // Overlapping in_ready is dropped, first result delivered once
        smp = '{1234, -321, 77, 4000};
        exp_a = model_mix();
        pulse_in();
        tick();
        smp = '{9, 9, 9, 9};
        pulse_in();
        expect_mix("overlap", exp_a, 2);
        check("overlap_dropped", dropped, 1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_ready) cnt++;
        end
        check("overlap_single_result", cnt, 0);

        // in_ready coincident with out_ready is accepted
        smp = '{-7000, 3000, 2500, 11};
        exp_a = model_mix();
        pulse_in();
        expect_mix("back2back_a", exp_a, 0);
        smp = '{100, 200, 300, -400};
        exp_b = model_mix();
        pulse_in();
        expect_mix("back2back_b", exp_b, 0);

        // Reset during ACCUM aborts the mix
        smp = '{5000, 5000, 5000, 5000};
        pulse_in();
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out", out, 0);
        check("abort_dropped", dropped, 0);
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_ready) cnt++;
        end
        check("abort_no_out_ready", cnt, 0);

        // Randomised gains/mutes/samples against the model, some with mid-mix gain edits
        for (int it = 0; it < 12; it++) begin
            for (int g = 0; g < 2; g++) begin
                int sel;
                sel = int'($urandom_range(3));
                gain_pulse(sel, 1'($urandom_range(1)), 1'($urandom_range(1)),
                           ($urandom_range(3) == 0));
                check($sformatf("rnd%0d_sel_gain", it), sel_gain, m_gain[sel]);
            end
            for (int ch = 0; ch < 4; ch++) smp[ch] = int'($urandom_range(65535)) - 32768;
            exp_a = model_mix();
            pulse_in();
            n0 = 0;
            if (it % 3 == 0) begin
                gain_pulse(int'($urandom_range(3)), 1'b1, 1'b0, 1'b1);
                n0 = 1;
            end
            expect_mix($sformatf("rnd%0d", it), exp_a, n0);
        end
        for (int s = 0; s < 4; s++) begin
            gain_sel = 2'(s);
            #1;
            check($sformatf("final_sel_gain%0d", s), sel_gain, m_gain[s]);
        end
        check("final_dropped", dropped, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, default 4, number of voice channels.
- SAMPLE_W, default 16, signed sample width.
- GAIN_W, default 4, unsigned per-channel gain width.
- GAIN_SHIFT, default 3, gain fraction bits, so unity gain is 8.
REQ-002 The design SHALL use one clock and an asynchronous, active-high reset. Ports are listed below in the form: name, direction, width, meaning.
REQ-003 clk, in, 1: system clock; all logic is rising-edge.
REQ-004 reset, in, 1: asynchronous, active-high reset.
REQ-005 in_ready, in, 1: one-cycle strobe; a new sample set is present on samples_in.
REQ-006 samples_in, in, NUM_CH*SAMPLE_W: packed signed samples, channel 0 in the LSBs.
REQ-007 gain_sel, in, clog2(NUM_CH): channel targeted by gain and mute controls.
REQ-008 gain_up, in, 1: one-cycle pulse; increment the gain of channel gain_sel.
REQ-009 gain_down, in, 1: one-cycle pulse; decrement the gain of channel gain_sel.
REQ-010 mute_toggle, in, 1: one-cycle pulse; invert the mute bit of channel gain_sel.
REQ-011 out, out, SAMPLE_W: signed mixed sample; held between updates.
REQ-012 out_ready, out, 1: one-cycle pulse; out has just been updated.
REQ-013 busy, out, 1: high while the mixer is not in IDLE.
REQ-014 dropped, out, 1: sticky flag; an in_ready arrived while busy.
REQ-015 sel_gain, out, GAIN_W: gain of channel gain_sel, for LED/display use.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and SAT.
REQ-017 In IDLE with in_ready=1, the block SHALL:
- latch samples_in, plus a snapshot of all gains and mute bits;
- clear the accumulator and set channel index idx=0;
- go to ACCUM.
REQ-018 In ACCUM, on each cycle, the block SHALL add term(idx) to the accumulator and increment idx. After adding term NUM_CH-1 it SHALL go to SAT.
REQ-019 term(i) SHALL be 0 when channel i is muted. Otherwise term(i) = (sample_i * gain_i) arithmetically shifted right by GAIN_SHIFT.
REQ-020 The accumulator SHALL be SAMPLE_W+GAIN_W+clog2(NUM_CH) bits wide and signed, so it never overflows.
REQ-021 In SAT, the block SHALL:
- register the accumulator into out, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1];
- assert out_ready for the following cycle only;
- return to IDLE.
REQ-022 Latency SHALL be exactly NUM_CH+2 clock edges from the edge that samples in_ready to the edge that raises out_ready. For NUM_CH=4 this is 6 edges.
REQ-023 An in_ready in the cycle that out_ready is high SHALL be accepted, because the FSM is then in IDLE.
REQ-024 An in_ready while busy=1 SHALL be ignored and SHALL set dropped=1. Only reset clears dropped.
REQ-025 gain_up SHALL increment the selected gain, saturating at 2^GAIN_W-1.
REQ-026 gain_down SHALL decrement the selected gain, saturating at 0.
REQ-027 Simultaneous gain_up and gain_down SHALL leave the gain unchanged.
REQ-028 If gain_sel >= NUM_CH, gain_up, gain_down and mute_toggle SHALL be ignored and sel_gain SHALL read 0.
REQ-029 Gain and mute updates SHALL be accepted in any state. They take effect only at the next IDLE capture; a mix already in progress uses its snapshot.
REQ-030 sel_gain SHALL be combinational from the live gain register.

Reset
REQ-031 While reset=1, the block SHALL hold:
- out=0, out_ready=0, busy=0, dropped=0;
- FSM in IDLE, accumulator and idx at 0;
- all gains at 2^GAIN_SHIFT (unity) and all mute bits at 0.
REQ-032 Reset asserted mid-ACCUM or in SAT SHALL abort the mix immediately. No out_ready SHALL follow reset release.

Structure
REQ-033 The FSM state encoding and the unity-gain constant SHALL live in the shared package voice_mixer_pkg.
REQ-034 The gain and mute registers SHALL be one sub-module, mixer_gain_bank. It takes gain_sel, gain_up, gain_down and mute_toggle as inputs and outputs the packed gains, the mute mask and sel_gain.
REQ-035 The datapath SHALL use a single multiplier, time-multiplexed by idx. There SHALL be no NUM_CH-wide parallel multiply.

Verification
(All scenarios use NUM_CH=4, SAMPLE_W=16, GAIN_W=4, GAIN_SHIFT=3.)
REQ-036 Reset: release reset -> out=0, out_ready=0, busy=0, dropped=0, and sel_gain=8 for gain_sel=0..3.
REQ-037 Unity mix: samples 1000, 2000, -500, 100 with one in_ready pulse -> out=2600, out_ready high for exactly 1 cycle, 6 edges after the in_ready edge; busy high for 5 cycles.
REQ-038 Saturation: all samples 30000 -> out=32767. All samples -30000 -> out=-32768.
REQ-039 Gain/mute:
- gain_sel=1 with 4 gain_down pulses -> sel_gain=4; then samples 0, 1000, 0, 0 -> out=500.
- 10 more gain_down pulses -> sel_gain=0.
- 20 gain_up pulses -> sel_gain=15.
- mute_toggle on channel 1 with sample 1000 -> out=0.
REQ-040 Overlap: a second in_ready 2 cycles after the first -> dropped=1 and a single out_ready carrying the first set's result. An in_ready coincident with out_ready -> accepted, with a second result 6 edges later.
REQ-041 Reset mid-ACCUM: reset asserted 2 cycles after in_ready -> busy=0 and out=0 at once. No out_ready for 10 cycles after release.
